// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: bundles the PSRAM user-side command/data bus and both
// requester ports of the arbiter.
//   slave  modport - the arbiter's view (drives commands, grants, read beats)
//   master modport - the requester/controller view (drives requests, beats)
// Signals:
//   init_calib                          controller calibration done
//   psram_cmd_en/cmd/addr/wr_data/mask  command strobe, 1=write, address, beat, mask
//   psram_rd_data/rd_valid              read beats from the controller
//   pN_req/we/addr/wdata/wmask          per-port request and write beat
//   pN_ack/wpop/rvalid/done             grant, beat consumed, read beat, burst end
//   rdata, timeout_err                  shared read beat, sticky read timeout
interface psram_arbiter_if;
    logic        init_calib;
    logic        psram_cmd_en;
    logic        psram_cmd;
    logic [20:0] psram_addr;
    logic [63:0] psram_wr_data;
    logic [7:0]  psram_mask;
    logic [63:0] psram_rd_data;
    logic        psram_rd_valid;

    logic        p0_req;
    logic        p0_we;
    logic [20:0] p0_addr;
    logic [63:0] p0_wdata;
    logic [7:0]  p0_wmask;
    logic        p0_ack;
    logic        p0_wpop;
    logic        p0_rvalid;
    logic        p0_done;

    logic        p1_req;
    logic        p1_we;
    logic [20:0] p1_addr;
    logic [63:0] p1_wdata;
    logic [7:0]  p1_wmask;
    logic        p1_ack;
    logic        p1_wpop;
    logic        p1_rvalid;
    logic        p1_done;

    logic [63:0] rdata;
    logic        timeout_err;

    modport slave (
        input  init_calib, psram_rd_data, psram_rd_valid,
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_wmask,
        output psram_cmd_en, psram_cmd, psram_addr, psram_wr_data, psram_mask,
        output p0_ack, p0_wpop, p0_rvalid, p0_done,
        output p1_ack, p1_wpop, p1_rvalid, p1_done,
        output rdata, timeout_err
    );

    modport master (
        output init_calib, psram_rd_data, psram_rd_valid,
        output p0_req, p0_we, p0_addr, p0_wdata, p0_wmask,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_wmask,
        input  psram_cmd_en, psram_cmd, psram_addr, psram_wr_data, psram_mask,
        input  p0_ack, p0_wpop, p0_rvalid, p0_done,
        input  p1_ack, p1_wpop, p1_rvalid, p1_done,
        input  rdata, timeout_err
    );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port arbiter in front of a PSRAM controller user port.
// Port 0 (display) has priority; port 1 (host) wins after STARVE_LIMIT
// consecutive port-0 grants while it waits. Each grant issues one burst
// command of BURST_BEATS 64-bit beats, commands are spaced at least CMD_GAP
// cycles apart, and a read with no first beat within RD_TIMEOUT cycles ends
// with a sticky timeout_err.
// Ports:
//   clk  - system clock (PSRAM user side and both requesters)
//   rst  - synchronous active-high reset
//   bus  - psram_arbiter_if.slave (PSRAM command/data side and both ports)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CALIB | waiting for init_calib; no grants
// ST_IDLE  | arbitrating; grants when a port requests and the gap elapsed
// ST_WRITE | streaming write beats from the granted port
// ST_READ  | forwarding read beats; read timeout running until first beat
// ST_GAP   | holding off until the command spacing has elapsed
module psram_arbiter #(
    parameter int BURST_BEATS  = 4,
    parameter int CMD_GAP      = 14,
    parameter int RD_TIMEOUT   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic            clk,
    input logic            rst,
    psram_arbiter_if.slave bus
);
    localparam int BW = $clog2(BURST_BEATS + 1);
    localparam int GW = $clog2(CMD_GAP + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_BEATS - 1);
    localparam logic [BW-1:0] PENULT     = BW'(BURST_BEATS - 2);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(CMD_GAP - 1);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(RD_TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_GAP
    } state_t;

    state_t      state;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] beat;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic        port;
    logic        cmd_en;
    logic        cmd;
    logic [20:0] addr;
    logic [1:0]  ack;
    logic [1:0]  wpop;
    logic [1:0]  rvalid;
    logic [1:0]  done;
    logic [63:0] rdata;
    logic        timeout_err;

    logic        req_any;
    logic        grant_port;
    logic        grant_we;
    logic [20:0] grant_addr;

    assign req_any    = bus.p0_req | bus.p1_req;
    assign grant_port = bus.p1_req & (~bus.p0_req | (starve_cnt == STARVE_MAX));
    assign grant_we   = grant_port ? bus.p1_we : bus.p0_we;
    assign grant_addr = grant_port ? bus.p1_addr : bus.p0_addr;

    // Gap and timeout are down-counters loaded at cmd_en; zero means expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CALIB;
            starve_cnt  <= '0;
            beat        <= '0;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            port        <= 1'b0;
            cmd_en      <= 1'b0;
            cmd         <= 1'b0;
            addr        <= '0;
            ack         <= '0;
            wpop        <= '0;
            rvalid      <= '0;
            done        <= '0;
            rdata       <= '0;
            timeout_err <= 1'b0;
        end else begin
            cmd_en <= 1'b0;
            ack    <= '0;
            wpop   <= '0;
            rvalid <= '0;
            done   <= '0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            if (!bus.p1_req) starve_cnt <= '0;

            if (!bus.init_calib) begin
                state <= ST_CALIB;
            end else begin
                case (state)
                    ST_CALIB: state <= ST_IDLE;
                    ST_IDLE: begin
                        if (req_any && gap_cnt == '0) begin
                            port             <= grant_port;
                            cmd              <= grant_we;
                            addr             <= grant_addr;
                            cmd_en           <= 1'b1;
                            ack[grant_port]  <= 1'b1;
                            beat             <= '0;
                            gap_cnt          <= GAP_LOAD;
                            tmo_cnt          <= TMO_LOAD;
                            if (grant_port)
                                starve_cnt <= '0;
                            else if (bus.p1_req && starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 1'b1;
                            if (grant_we) begin
                                wpop[grant_port] <= 1'b1;
                                done[grant_port] <= (BURST_BEATS == 1);
                                state            <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                    ST_WRITE: begin
                        // beat holds the index of the beat on the bus this cycle
                        if (beat == LAST_BEAT) begin
                            state <= ST_GAP;
                        end else begin
                            beat       <= beat + 1'b1;
                            wpop[port] <= 1'b1;
                            done[port] <= (beat == PENULT);
                        end
                    end
                    ST_READ: begin
                        if (bus.psram_rd_valid) begin
                            rdata        <= bus.psram_rd_data;
                            rvalid[port] <= 1'b1;
                            if (beat == LAST_BEAT) begin
                                done[port] <= 1'b1;
                                state      <= ST_GAP;
                            end else begin
                                beat <= beat + 1'b1;
                            end
                        end else if (beat == '0) begin
                            if (tmo_cnt == '0) begin
                                timeout_err <= 1'b1;
                                done[port]  <= 1'b1;
                                state       <= ST_GAP;
                            end else begin
                                tmo_cnt <= tmo_cnt - 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        // leave one cycle early so IDLE grants exactly when the gap expires
                        if (gap_cnt <= GW'(1)) state <= ST_IDLE;
                    end
                    default: state <= ST_CALIB;
                endcase
            end
        end
    end

    assign bus.psram_cmd_en  = cmd_en;
    assign bus.psram_cmd     = cmd;
    assign bus.psram_addr    = addr;
    assign bus.psram_wr_data = port ? bus.p1_wdata : bus.p0_wdata;
    assign bus.psram_mask    = port ? bus.p1_wmask : bus.p0_wmask;
    assign bus.p0_ack        = ack[0];
    assign bus.p1_ack        = ack[1];
    assign bus.p0_wpop       = wpop[0];
    assign bus.p1_wpop       = wpop[1];
    assign bus.p0_rvalid     = rvalid[0];
    assign bus.p1_rvalid     = rvalid[1];
    assign bus.p0_done       = done[0];
    assign bus.p1_done       = done[1];
    assign bus.rdata         = rdata;
    assign bus.timeout_err   = timeout_err;
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed bench for psram_arbiter with default parameters.
// Outputs are sampled 1 ns after each rising edge; inputs are driven there too.
module tb_psram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    psram_arbiter_if bus ();

    psram_arbiter #(
        .BURST_BEATS (4),
        .CMD_GAP     (14),
        .RD_TIMEOUT  (64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [8:0] strobes();
        return {bus.p1_done, bus.p0_done, bus.p1_rvalid, bus.p0_rvalid,
                bus.p1_wpop, bus.p0_wpop, bus.p1_ack, bus.p0_ack, bus.psram_cmd_en};
    endfunction

    task automatic wait_cmd(input string tag, input int limit);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.psram_cmd_en !== 1'b1 && n < limit);
        chk(tag, bus.psram_cmd_en, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          got;
        int          idx;
        int          c0;
        int          dcyc;
        logic        te63;
        logic        te_at;
        logic        pw;
        logic [63:0] wbeat [4];
        int          tcmd  [6];
        logic        gport [6];

        wbeat = '{64'h11, 64'h22, 64'h33, 64'h44};
        rst = 1'b1;
        bus.init_calib     = 1'b0;
        bus.psram_rd_valid = 1'b0;
        bus.psram_rd_data  = '0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wmask = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wmask = '0;
        repeat (3) tick();
        chk("rst_strobes", strobes(), 9'd0);
        chk("rst_cmd", bus.psram_cmd, 1'b0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_timeout_err", bus.timeout_err, 1'b0);

        // No grants while calibrating; grant on the second cycle after the rise.
        rst = 1'b0;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 21'h12345;
        n = 0;
        repeat (20) begin
            tick();
            if (bus.psram_cmd_en || bus.p0_ack) n++;
        end
        chk("calib_no_cmd", n, 0);
        bus.init_calib = 1'b1;
        tick();
        chk("calib_first_cycle", bus.psram_cmd_en, 1'b0);
        tick();
        chk("calib_cmd_en", bus.psram_cmd_en, 1'b1);
        chk("calib_ack", {bus.p1_ack, bus.p0_ack}, 2'b01);
        chk("rd_cmd", bus.psram_cmd, 1'b0);
        chk("rd_addr", bus.psram_addr, 21'h12345);
        bus.p0_req = 1'b0;

        // Read: beats at cmd_en+5..+8, rvalid one cycle later; stray beats after are ignored.
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("rd_rvalid_%0d", k), {bus.p1_rvalid, bus.p0_rvalid},
                (k >= 6 && k <= 9) ? 2'b01 : 2'b00);
            chk($sformatf("rd_done_%0d", k), bus.p0_done, k == 9);
            if (k >= 6 && k <= 9)
                chk($sformatf("rd_data_%0d", k), bus.rdata, 64'hA000 + 64'(k - 1));
            bus.psram_rd_valid = (k >= 5 && k <= 10);
            bus.psram_rd_data  = 64'hA000 + 64'(k);
        end
        bus.psram_rd_valid = 1'b0;

        // Port-1 write burst.
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 21'h0ABCD;
        bus.p1_wmask = 8'h0F; idx = 0; bus.p1_wdata = wbeat[0];
        wait_cmd("wr_grant", 40);
        chk("wr_ack", {bus.p1_ack, bus.p0_ack}, 2'b10);
        chk("wr_cmd", bus.psram_cmd, 1'b1);
        chk("wr_addr", bus.psram_addr, 21'h0ABCD);
        chk("wr_mask", bus.psram_mask, 8'h0F);
        bus.p1_req = 1'b0;
        got = 0;
        pw  = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (b > 0) begin
                tick();
                if (pw && idx < 3) begin
                    idx++;
                    bus.p1_wdata = wbeat[idx];
                end
                #1;
            end
            if (bus.p1_wpop) got++;
            if (b < 4) chk($sformatf("wr_data_%0d", b), bus.psram_wr_data, 64'h11 * 64'(b + 1));
            chk($sformatf("wr_wpop_%0d", b), bus.p1_wpop, b < 4);
            chk($sformatf("wr_done_%0d", b), bus.p1_done, b == 3);
            pw = bus.p1_wpop;
        end
        chk("wr_wpop_count", got, 4);

        // Both ports requesting continuously: p0 x4, p1, p0; 14-cycle spacing.
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 21'h00010;
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 21'h00020;
        for (int g = 0; g < 6; g++) begin
            wait_cmd($sformatf("arb_grant_%0d", g), 40);
            tcmd[g]  = cyc;
            gport[g] = bus.p1_ack;
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        for (int g = 0; g < 6; g++)
            chk($sformatf("arb_order_%0d", g), gport[g], g == 4);
        for (int g = 1; g < 6; g++)
            chk($sformatf("arb_spacing_%0d", g), tcmd[g] - tcmd[g-1], 14);
        repeat (20) tick();

        // Read with no data: timeout at cmd_en+64, next grant at +66.
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 21'h00777;
        wait_cmd("tmo_grant", 40);
        c0 = cyc;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 21'h1F000;
        n = 0; dcyc = -1; te63 = 1'b1; te_at = 1'b0;
        for (int k = 1; k <= 80 && dcyc < 0; k++) begin
            tick();
            if (k == 63) te63 = bus.timeout_err;
            if (bus.p0_rvalid || bus.psram_cmd_en) n++;
            if (bus.p0_done) begin
                dcyc  = k;
                te_at = bus.timeout_err;
            end
        end
        chk("tmo_done_cycle", dcyc, 64);
        chk("tmo_err_set", te_at, 1'b1);
        chk("tmo_err_before", te63, 1'b0);
        chk("tmo_no_activity", n, 0);
        wait_cmd("tmo_next_grant", 10);
        chk("tmo_next_spacing", cyc - c0, 66);
        chk("tmo_next_ack", bus.p1_ack, 1'b1);
        bus.p1_req = 1'b0;

        // Reset during write beat 2 of that p1 burst.
        tick();
        tick();
        chk("rstmid_beat2_wpop", bus.p1_wpop, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstmid_strobes", strobes(), 9'd0);
        chk("rstmid_cmd", bus.psram_cmd, 1'b0);
        chk("rstmid_rdata", bus.rdata, 64'd0);
        chk("rstmid_timeout_err", bus.timeout_err, 1'b0);
        rst = 1'b0;
        bus.p1_req = 1'b1; bus.p1_addr = 21'h00100;
        tick();
        chk("rstmid_no_done", bus.p1_done, 1'b0);
        chk("rstmid_calib_cycle", bus.psram_cmd_en, 1'b0);
        tick();
        chk("rstmid_regrant", {bus.psram_cmd_en, bus.p1_ack}, 2'b11);
        bus.p1_req = 1'b0;
        got = bus.p1_wpop ? 1 : 0;
        n   = bus.p1_done ? 1 : 0;
        repeat (4) begin
            tick();
            if (bus.p1_wpop) got++;
            if (bus.p1_done) n++;
        end
        chk("rstmid_wpop_count", got, 4);
        chk("rstmid_done_count", n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter BURST_BEATS, default 4: 64-bit data beats per PSRAM command.
REQ-002 Parameter CMD_GAP, default 14: minimum clk cycles from one cmd_en pulse to the next.
REQ-003 Parameter RD_TIMEOUT, default 64: cycles allowed for the first read beat after a read command.
REQ-004 Parameter STARVE_LIMIT, default 4: consecutive port-0 grants allowed while port 1 is pending.
REQ-005 clk  in  1  system clock; the PSRAM user side and both requesters run on it.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 init_calib  in  1  PSRAM controller calibration done.
REQ-008 psram_cmd_en / psram_cmd  out  1/1  command strobe; cmd 1=write, 0=read.
REQ-009 psram_addr / psram_wr_data / psram_mask  out  21/64/8  command address, write beat, byte mask (1=masked).
REQ-010 psram_rd_data / psram_rd_valid  in  64/1  read beats from the controller.
REQ-011 pN_req / pN_we / pN_addr  in  1/1/21  per-port request for N=0 (display, high priority) and N=1 (host); the port holds these until pN_ack.
REQ-012 pN_wdata / pN_wmask  in  64/8  per-port write beat; the port advances to the next beat after each pN_wpop.
REQ-013 pN_ack / pN_wpop / pN_rvalid / pN_done  out  1 each  grant pulse, write-beat consumed, read beat valid, burst complete.
REQ-014 rdata  out  64  read beat, shared by both ports and qualified by pN_rvalid.
REQ-015 timeout_err  out  1  sticky flag set by a read timeout.

Function
REQ-016 States: CALIB, IDLE, WRITE, READ, GAP.
REQ-017 CALIB: no grants; moves to IDLE on the first cycle init_calib=1.
REQ-018 IDLE arbitration: if only one port requests, that port wins.
REQ-019 IDLE arbitration: if both ports request, port 0 wins unless starve_cnt==STARVE_LIMIT, in which case port 1 wins.
REQ-020 starve_cnt: increments on a port-0 grant while p1_req=1, saturating at STARVE_LIMIT; clears on any port-1 grant or when p1_req=0.
REQ-021 Grant cycle outputs: pN_ack=1 for exactly one cycle; psram_cmd_en=1 in the same cycle, with psram_addr=pN_addr and psram_cmd=pN_we.
REQ-022 Grant cycle bookkeeping: the port number, we and addr are latched.
REQ-023 Next state after a grant: WRITE if we=1, else READ.
REQ-024 Write beats: the first beat drives psram_wr_data/psram_mask combinationally from the granted port in the cmd_en cycle.
REQ-025 Write beats: beats 1..BURST_BEATS-1 follow on consecutive cycles with no gaps.
REQ-026 Write beats: pN_wpop=1 in every beat cycle (BURST_BEATS pulses in total).
REQ-027 Write completion: after the last beat, pN_done pulses for one cycle and the state moves to GAP.
REQ-028 READ: each psram_rd_valid beat is forwarded to rdata with a one-cycle registered delay, and the granted port's pN_rvalid is asserted.
REQ-029 READ: the beat counter counts from 0 to BURST_BEATS-1.
REQ-030 READ: pN_done pulses together with the last pN_rvalid, then the state moves to GAP.
REQ-031 READ: psram_rd_valid in any state other than READ is ignored and produces no pN_rvalid.
REQ-032 Read timeout: if no beat arrives within RD_TIMEOUT cycles of cmd_en, set timeout_err, pulse pN_done without data, and move to GAP.
REQ-033 Read timeout: the timeout counter stops at the first beat.
REQ-034 GAP: a counter started at cmd_en blocks the next grant until CMD_GAP cycles have elapsed.
REQ-035 GAP: the earliest next cmd_en is exactly CMD_GAP cycles after the previous one.
REQ-036 GAP: exits to IDLE; if GAP is reached with the gap already elapsed, it still occupies one cycle.
REQ-037 init_calib falling in any state forces CALIB.
REQ-038 When init_calib falls, an in-flight burst is abandoned without pN_done; the port must re-request.
REQ-039 Counter widths: beat counter is clog2(BURST_BEATS+1) bits; gap and timeout counters are sized so they do not wrap before reaching their parameter value.
REQ-040 Outputs idle at 0 in every cycle they are not explicitly driven: cmd_en, ack, wpop, rvalid, done.
REQ-041 psram_wr_data, psram_mask and psram_addr are don't-care outside their command and beat cycles.

Reset
REQ-042 rst=1 at a clk edge: state=CALIB; starve_cnt, beat, gap and timeout counters=0.
REQ-043 rst=1 at a clk edge: timeout_err=0, rdata=0, and every 1-bit output=0.
REQ-044 rst mid-burst aborts the burst immediately; no pN_done is generated.

Verification
REQ-045 init_calib=0, p0_req=1 for 20 cycles -> no cmd_en. Raise init_calib -> p0_ack and cmd_en in the same cycle, on the second cycle after the rise.
REQ-046 p1 write with addr=0x0ABCD, beats 0x11..0x44 -> cmd_en with cmd=1 and addr=0x0ABCD. psram_wr_data=0x11,0x22,0x33,0x44 on 4 consecutive cycles, 4 p1_wpop pulses, p1_done on the 4th beat.
REQ-047 p0 read; model returns 4 beats starting 5 cycles after cmd_en -> p0_rvalid x4, one cycle after each rd_valid, matching data. p0_done with the 4th; p1_rvalid stays 0 throughout.
REQ-048 p0_req and p1_req held high continuously -> grant order p0,p0,p0,p0,p1,p0,... and cmd_en spacing exactly 14 cycles.
REQ-049 Read where the model never returns data -> timeout_err=1 and p0_done 64 cycles after cmd_en; the next grant is allowed afterwards.
REQ-050 rst=1 during write beat 2 -> the next cycle shows state CALIB, all strobes 0, no p1_done; normal operation resumes after init_calib.
